program_counter: RTL and testbench
==================================

# program_counter

Registered binary program counter for the SAP-2 8-bit CPU datapath. It holds the address of the next instruction. Each cycle it can clear, load a jump target, increment, or hold. The control sequencer drives `enable` and `load`, and `counter_out` feeds the memory address register.

## Interface
Parameters:
- `WIDTH`, default 4: counter width in bits.
- `RESET_VALUE`, default 0: value loaded on reset. Must fit in `WIDTH` bits.

Ports:
- `clk`, input, 1 bit: single system clock; all state updates on its rising edge.
- `reset`, input, 1 bit: synchronous, active-low reset; sampled only at the rising edge of `clk`.
- `enable`, input, 1 bit: increment request, active-high.
- `load`, input, 1 bit: parallel load request, active-high.
- `counter_in`, input, `WIDTH` bits: jump target, captured when `load` is 1.
- `counter_out`, output, `WIDTH` bits: current counter value, driven directly from the state register.
- `wrap`, output, 1 bit: present only with `PC_WRAP_FLAG_EN` (see Configuration).

## Operation
- Rising-edge action, in priority order:
  1. `reset` = 0: counter becomes `RESET_VALUE`.
  2. `load` = 1: counter becomes `counter_in`.
  3. `enable` = 1: counter becomes counter + 1, modulo 2^`WIDTH`.
  4. Otherwise: hold.
- `load` overrides `enable`. With both at 1, the loaded value is stored and is not incremented in that cycle.
- Reset overrides both `load` and `enable`.
- Arithmetic is unsigned with wrap-around: all-ones + 1 = 0. There is no saturation and no error indication unless `PC_WRAP_FLAG_EN` is defined.
- `counter_in` is ignored when `load` = 0.
- No combinational path exists from any input to `counter_out`.
- Initial value before the first reset is undefined. Reset must be asserted for at least one rising edge before use.

## Timing
- Latency: every operation is visible on `counter_out` one cycle after the controlling inputs are sampled, i.e. after the rising edge.
- Reset value: `counter_out` = `RESET_VALUE`, and `wrap` = 0 if present.
- Reset asserted mid-count, or in the same cycle as `load` or `enable`: the result is `RESET_VALUE` at that edge.
- When `reset` is released with `enable` = 1, the first increment occurs at the next rising edge. `counter_out` = `RESET_VALUE` + 1 after that edge.
- After a load with `enable` still 1, counting resumes from the loaded value at the following edge.
- Inputs must be stable around the rising edge. The reference stimulus style changes inputs on the falling edge.

## Configuration
- Macro: `PC_WRAP_FLAG_EN`.
- Defined:
  - Adds the registered output `wrap`.
  - `wrap` = 1 for exactly the one cycle after an increment from all-ones to zero.
  - `wrap` = 0 after reset, after a load (including a load of 0), and after hold cycles.
- Undefined: the `wrap` port and its logic are absent; all other behaviour is identical.

## Test plan
- Reset and count:
  - Hold `reset` = 0 for one edge, then release with `enable` = 1.
  - After the first edge: 0001.
  - After three more edges: 0100.
- Load with enable:
  - At value 0100, set `load` = 1, `enable` = 1, `counter_in` = 1010.
  - Next edge gives 1010 (no increment).
  - Drop `load`; next edge gives 1011.
- Reset mid-count: with `enable` = 1 at 1011, assert `reset` = 0 → 0000 at the next edge, and it stays 0000 while reset is held.
- Hold: `enable` = 0, `load` = 0 at 0110 for 5 edges → 0110 throughout, and `counter_in` changes are ignored.
- Wrap:
  - Load 1111, then `enable` = 1 → 0000 at the next edge.
  - With `PC_WRAP_FLAG_EN`: `wrap` = 1 for that cycle only, and 0 after the following increment to 0001.
- Priority: `reset` = 0, `load` = 1, `enable` = 1, `counter_in` = 0111 → 0000.

Source files
------------

// File: rtl/program_counter.sv
// Registered program counter for the SAP-2 datapath: synchronous clear, load, increment or hold.
// Optional PC_WRAP_FLAG_EN adds a registered one-cycle wrap flag on the all-ones to zero increment.
module program_counter #(
   parameter int unsigned WIDTH       = 4,
   parameter int unsigned RESET_VALUE = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             load,
   input  logic [WIDTH-1:0] counter_in,
`ifdef PC_WRAP_FLAG_EN
   output logic             wrap,
`endif
   output logic [WIDTH-1:0] counter_out
);

   localparam logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_VALUE);
   localparam logic [WIDTH-1:0] ALL_ONES = '1;

   logic [WIDTH-1:0] pc_q;

   // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset) begin
         pc_q <= RESET_PC;
      end else if (load) begin
         pc_q <= counter_in;
      end else if (enable) begin
         pc_q <= pc_q + 1'b1;
      end
   end

`ifdef PC_WRAP_FLAG_EN
   // Flag is high only after the increment that rolls all-ones over to zero.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wrap <= 1'b0;
      end else begin
         wrap <= !load && enable && (pc_q == ALL_ONES);
      end
   end
`endif

   assign counter_out = pc_q;

endmodule

// File: tb/tb_program_counter.sv
// Scoreboard bench for program_counter: expectations queued at drive time, popped after the edge.
// Build with +define+PC_WRAP_FLAG_EN to also check the wrap flag.
module tb_program_counter;

   localparam int W = 4;

   typedef struct {
      string        tag;
      logic [W-1:0] pc;
      logic         wrap;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset;
   logic         enable;
   logic         load;
   logic [W-1:0] counter_in;
   logic [W-1:0] counter_out;
`ifdef PC_WRAP_FLAG_EN
   logic         wrap;
`endif

   exp_t         sb_q[$];
   int           n_cmp = 0;
   int           n_bad = 0;
   logic [W-1:0] m_pc;
   logic         m_wrap;
   bit           m_valid = 1'b0;

   program_counter #(.WIDTH(W), .RESET_VALUE(0)) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .load        (load),
      .counter_in  (counter_in),
`ifdef PC_WRAP_FLAG_EN
      .wrap        (wrap),
`endif
      .counter_out (counter_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   // Drives one cycle on the falling edge, models it, and scores the result after the next rising edge.
   task automatic step(input string tag, input logic rst, input logic ld, input logic en,
                       input logic [W-1:0] din);
      exp_t e;
      @(negedge clk);
      reset = rst; load = ld; enable = en; counter_in = din;
      #1;
      if (m_valid) check({tag, "/no_comb"}, 32'(counter_out), 32'(m_pc));
      if (!rst) begin
         m_pc = '0; m_wrap = 1'b0;
      end else if (ld) begin
         m_pc = din; m_wrap = 1'b0;
      end else if (en) begin
         m_wrap = (m_pc == 4'hF);
         m_pc   = m_pc + 4'd1;
      end else begin
         m_wrap = 1'b0;
      end
      m_valid = 1'b1;
      e.tag = tag; e.pc = m_pc; e.wrap = m_wrap;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      check(e.tag, 32'(counter_out), 32'(e.pc));
`ifdef PC_WRAP_FLAG_EN
      check({e.tag, "/wrap"}, 32'(wrap), 32'(e.wrap));
`endif
   endtask

   initial begin
      reset = 1'b0; load = 1'b0; enable = 1'b0; counter_in = '0;

      step("reset", 0, 0, 0, 4'h0);
      step("first_inc", 1, 0, 1, 4'h0);
      for (int i = 0; i < 3; i++) step("count", 1, 0, 1, 4'h0);

      step("load_over_en", 1, 1, 1, 4'hA);
      step("resume", 1, 0, 1, 4'h3);

      step("reset_mid", 0, 0, 1, 4'h0);
      step("reset_held", 0, 0, 1, 4'h5);
      step("reset_held", 0, 1, 0, 4'h9);

      step("load6", 1, 1, 0, 4'h6);
      for (int i = 0; i < 5; i++) step("hold", 1, 0, 0, 4'($urandom_range(0, 15)));

      step("load15", 1, 1, 0, 4'hF);
      step("wrap_to0", 1, 0, 1, 4'h2);
      step("after_wrap", 1, 0, 1, 4'h2);

      step("load14", 1, 1, 0, 4'hE);
      step("to15", 1, 0, 1, 4'h0);
      step("load0_at15", 1, 1, 1, 4'h0);

      step("priority", 0, 1, 1, 4'h7);

      for (int i = 0; i < 40; i++)
         step("random", ($urandom_range(0, 9) != 0), ($urandom_range(0, 3) == 0),
              1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));

      check("sb_empty", 32'(sb_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
